// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the oversampled UART receiver.
// The state enum always lists PARITY; only the parity build ever enters it.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  localparam int         OVERSAMPLE = 16;
  localparam int         DATA_BITS  = 8;
  localparam logic [3:0] MID_TICK   = 4'd7;
  localparam logic [3:0] LAST_TICK  = 4'd15;
  localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);

  // Rounded clocks-per-tick, never below one.
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    int q;
    q = (clk_hz + (baud * ovs) / 2) / (baud * ovs);
    if (q < 1) begin
      q = 1;
    end else begin
      q = q;
    end
    return q;
  endfunction

  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    return ~(^{data, par});
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: push is dropped when full unless a pop happens the same cycle.
// The head byte and the valid flag are both registered; there is no empty bypass.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam int             CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q;
  logic             full_s;
  logic             pop_s;
  logic             wr_en_s;

  assign full_s  = (count_q == FULL_CNT);
  assign pop_s   = pop_i && valid_q;
  assign wr_en_s = push_i && (!full_s || pop_s);

  // Next pointers, occupancy and head byte; the head must see a same-cycle write.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (count_d == {CNT_W{1'b0}}) begin
      head_d = {WIDTH{1'b0}};
    end else if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      head_q   <= {WIDTH{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != {CNT_W{1'b0}});
    end
  end

  assign full_o  = full_s;
  assign valid_o = valid_q;
  assign head_o  = head_q;

endmodule

// File: rtl/uart_rx_core.sv
// 16x oversampled UART receiver (8N1) feeding a small FIFO with error flags.
// Define UART_RX_PARITY_EN for 8E1 frames with a live parity_err_o.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       rx_i,
  output logic       rd_valid_o,
  output logic [7:0] rd_data_o,
  input  logic       rd_ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o,
  input  logic       overrun_clr_i,
  output logic       busy_o
);

  localparam int               DIV      = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic             sync1_q, sync2_q;
  logic             rxs_s;
  logic [DIV_W-1:0] div_cnt_q;
  logic             tick_s;
  rx_state_e        state_q, state_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_s;
  logic             frame_err_q, frame_err_d;
  logic             busy_q;
  logic             overrun_q, overrun_d;
  logic             fifo_full_s;
  logic             pop_s;
`ifdef UART_RX_PARITY_EN
  logic             par_err_q, par_err_d;
  logic             parity_err_q, parity_err_d;
`endif

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  assign rxs_s  = sync2_q;
  assign tick_s = (state_q != IDLE) && (div_cnt_q == DIV_LAST);

  // Tick divider, held at zero while idle so each frame starts phase-aligned.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_cnt_q <= {DIV_W{1'b0}};
    end else if ((state_q == IDLE) || tick_s) begin
      div_cnt_q <= {DIV_W{1'b0}};
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  // Frame FSM: next state, bit sampling and single-cycle event strobes.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push_s      = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d    = par_err_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rxs_s) begin
          state_d    = START;
          tick_cnt_d = 4'd0;
          bit_cnt_d  = 3'd0;
`ifdef UART_RX_PARITY_EN
          par_err_d  = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s && (tick_cnt_q == MID_TICK)) begin
          tick_cnt_d = 4'd0;
          state_d    = rxs_s ? IDLE : DATA;
        end else if (tick_s) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      DATA: begin
        if (tick_s && (tick_cnt_q == LAST_TICK)) begin
          tick_cnt_d = 4'd0;
          shift_d    = {rxs_s, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            state_d = DATA;
          end
        end else if (tick_s) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_s && (tick_cnt_q == LAST_TICK)) begin
          tick_cnt_d = 4'd0;
          par_err_d  = ~even_parity_ok(shift_q, rxs_s);
          state_d    = STOP;
        end else if (tick_s) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
`endif
      STOP: begin
        if (tick_s && (tick_cnt_q == LAST_TICK)) begin
          tick_cnt_d = 4'd0;
          if (!rxs_s) begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_err_q) begin
            parity_err_d = 1'b1;
            state_d      = IDLE;
`endif
          end else begin
            push_s  = 1'b1;
            state_d = IDLE;
          end
        end else if (tick_s) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      BREAK: begin
        if (rxs_s) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      tick_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

  assign pop_s = rd_valid_o && rd_ready_i;

  // A same-cycle pop frees the slot, so only a push into a full FIFO with no pop overruns.
  always_comb begin
    if (push_s && fifo_full_s && !pop_s) begin
      overrun_d = 1'b1;
    end else if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      busy_q      <= (state_d != IDLE);
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_err_q    <= par_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clock       (clock),
    .resetn      (resetn),
    .push_i      (push_s),
    .push_data_i (shift_q),
    .full_o      (fifo_full_s),
    .pop_i       (rd_ready_i),
    .valid_o     (rd_valid_o),
    .head_o      (rd_data_o)
  );

  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at 16 clocks per bit, with a queue-based
// reference model of the receive FIFO, overrun flag and error pulses.
module tb_uart_rx_core;

  logic       clock = 1'b0;
  logic       resetn;
  logic       rx_i;
  logic       rd_valid_o;
  logic [7:0] rd_data_o;
  logic       rd_ready_i;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       overrun_o;
  logic       overrun_clr_i;
  logic       busy_o;

  always #5 clock = ~clock;

  uart_rx_core #(
    .CLK_HZ     (1_843_200),
    .BAUD       (115200),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .rx_i          (rx_i),
    .rd_valid_o    (rd_valid_o),
    .rd_data_o     (rd_data_o),
    .rd_ready_i    (rd_ready_i),
    .frame_err_o   (frame_err_o),
    .parity_err_o  (parity_err_o),
    .overrun_o     (overrun_o),
    .overrun_clr_i (overrun_clr_i),
    .busy_o        (busy_o)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         chk_idx      = 0;
  int         frame_cycles = 0;
  int         par_cycles   = 0;
  int         busy_cycles  = 0;
  int         hold_viol    = 0;
  logic       prev_hold    = 1'b0;
  logic [7:0] prev_data    = 8'h00;
  logic       overrun_m    = 1'b0;

  // Monitor: record delivered bytes and count pulse/busy cycles, away from the clock edge.
  always @(negedge clock) begin
    if (resetn) begin
      if (rd_valid_o && rd_ready_i) got_q.push_back(rd_data_o);
      if (frame_err_o) frame_cycles <= frame_cycles + 1;
      if (parity_err_o) par_cycles <= par_cycles + 1;
      if (busy_o) busy_cycles <= busy_cycles + 1;
      if (prev_hold && rd_valid_o && (rd_data_o !== prev_data)) hold_viol <= hold_viol + 1;
      prev_hold <= rd_valid_o && !rd_ready_i;
      prev_data <= rd_data_o;
    end else begin
      prev_hold <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int stop_low, input logic bad_par);
    rx_i = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      step(16);
    end
`ifdef UART_RX_PARITY_EN
    rx_i = (^d) ^ bad_par;
    step(16);
`else
    if (bad_par) rx_i = 1'b1;
`endif
    if (stop_low > 0) begin
      rx_i = 1'b0;
      step(16 * stop_low);
    end
    rx_i = 1'b1;
    step(16);
  endtask

  // Reference model of a good frame arriving: enqueue or flag overrun.
  task automatic model_good(input logic [7:0] d);
    if ((exp_q.size() - got_q.size()) >= 8) overrun_m = 1'b1;
    else exp_q.push_back(d);
  endtask

  task automatic model_flush();
    while (exp_q.size() > got_q.size()) exp_q.pop_back();
    overrun_m = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = chk_idx; (i < exp_q.size()) && (i < got_q.size()); i++)
      check({tag, "_data"}, got_q[i], exp_q[i]);
    while (exp_q.size() < got_q.size()) exp_q.push_back(8'h00);
    while (exp_q.size() > got_q.size()) exp_q.pop_back();
    chk_idx = got_q.size();
  endtask

  initial begin
    int b0;
    logic [7:0] d;
    resetn        = 1'b1;
    rx_i          = 1'b1;
    rd_ready_i    = 1'b1;
    overrun_clr_i = 1'b0;
    #3 resetn = 1'b0;
    step(3);
    check("rst_valid", rd_valid_o, 1'b0);
    check("rst_data", rd_data_o, 8'h00);
    check("rst_frame", frame_err_o, 1'b0);
    check("rst_parity", parity_err_o, 1'b0);
    check("rst_overrun", overrun_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    resetn = 1'b1;
    step(10);
    check("idle_busy", busy_o, 1'b0);

    // Basic 0x55 frame
    b0 = frame_cycles;
    send_frame(8'h55, 0, 1'b0);
    model_good(8'h55);
    step(20);
    compare_all("f55");
    check("f55_frame_err", frame_cycles - b0, 0);
    check("f55_busy", busy_o, 1'b0);

    // Short low glitch on an idle line
    b0 = busy_cycles;
    rx_i = 1'b0;
    step(4);
    rx_i = 1'b1;
    step(30);
    check("glitch_busy_window", ((busy_cycles - b0) >= 1) && ((busy_cycles - b0) <= 10), 1'b1);
    compare_all("glitch");

    // Stop bit held low -> break, then a clean frame
    b0 = frame_cycles;
    send_frame(8'hA3, 3, 1'b0);
    step(20);
    check("break_frame_pulse", frame_cycles - b0, 1);
    compare_all("break");
    send_frame(8'h3C, 0, 1'b0);
    model_good(8'h3C);
    step(20);
    compare_all("after_break");

    // Random bytes, gaps and reader back-pressure
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      send_frame(d, 0, 1'b0);
      model_good(d);
      rd_ready_i = 1'($urandom_range(0, 1));
      step($urandom_range(0, 12));
    end
    rd_ready_i = 1'b1;
    step(30);
    compare_all("random");

    // Overrun: nine frames into an eight-entry FIFO with no reader
    rd_ready_i = 1'b0;
    for (int k = 0; k < 9; k++) begin
      send_frame(8'(k), 0, 1'b0);
      model_good(8'(k));
    end
    step(10);
    check("ovr_flag", overrun_o, overrun_m);
    check("ovr_valid", rd_valid_o, 1'b1);
    check("ovr_head", rd_data_o, exp_q[chk_idx]);
    rd_ready_i = 1'b1;
    step(20);
    compare_all("ovr_drain");
    check("ovr_sticky", overrun_o, overrun_m);
    overrun_clr_i = 1'b1;
    step(1);
    overrun_clr_i = 1'b0;
    overrun_m = 1'b0;
    step(1);
    check("ovr_cleared", overrun_o, overrun_m);

    // Reset in the middle of a frame while the FIFO holds a byte
    rd_ready_i = 1'b0;
    send_frame(8'h99, 0, 1'b0);
    model_good(8'h99);
    rx_i = 1'b0;
    step(16);
    rx_i = 1'b1;
    step(40);
    check("pre_rst_busy", busy_o, 1'b1);
    check("pre_rst_valid", rd_valid_o, 1'b1);
    resetn = 1'b0;
    #1;
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_valid", rd_valid_o, 1'b0);
    check("mid_rst_data", rd_data_o, 8'h00);
    model_flush();
    step(3);
    resetn = 1'b1;
    step(20);
    rd_ready_i = 1'b1;
    send_frame(8'h12, 0, 1'b0);
    model_good(8'h12);
    step(20);
    compare_all("post_rst");

`ifdef UART_RX_PARITY_EN
    b0 = par_cycles;
    send_frame(8'h07, 0, 1'b1);
    step(20);
    check("par_bad_pulse", par_cycles - b0, 1);
    compare_all("par_bad");
    send_frame(8'h07, 0, 1'b0);
    model_good(8'h07);
    step(20);
    compare_all("par_good");
`else
    check("par_never", par_cycles, 0);
`endif

    check("hold_stable", hold_viol, 0);
    check("end_busy", busy_o, 1'b0);
    check("end_overrun", overrun_o, overrun_m);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
